issue_stage_latch: RTL and testbench
====================================

Name: issue_stage_latch

Overview:
- Pipeline register and control between the schedule stage and register-read stage, one lane per issue slot.
- Captures each selected issue-queue pointer, holds it across stalls, and kills ops whose issue-queue entry is flushed by recovery.
- Reads the op payload from the issue-queue RAM and forwards valid ops downstream.
- Returns the freed issue-queue entry to the allocator and counts issued ops.

Parameters:
- ISSUE_WIDTH, 4, number of issue lanes.
- IQ_ENTRY_NUM, 16, issue-queue entries (power of two).
- IQ_PTR_W, $clog2(IQ_ENTRY_NUM), issue-queue pointer width.
- PAYLOAD_W, 64, issue-queue payload width per lane.
- CNT_W, 32, issued-op counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- stall  in  1  hold all lane latches.
- clear  in  1  invalidate all lane latches.
- sc_valid  in  ISSUE_WIDTH  per-lane op selected by scheduler this cycle.
- sc_ptr  in  ISSUE_WIDTH*IQ_PTR_W  per-lane selected entry pointer; lane i at bits [i*IQ_PTR_W +: IQ_PTR_W].
- flush_iq_entry  in  IQ_ENTRY_NUM  one-hot-or-zero-per-bit recovery flush mask over issue-queue entries.
- iq_rd_ptr  out  ISSUE_WIDTH*IQ_PTR_W  payload RAM read address, equal to the latched pointer.
- iq_rd_payload  in  ISSUE_WIDTH*PAYLOAD_W  combinational payload for iq_rd_ptr.
- rr_valid  out  ISSUE_WIDTH  op presented to register-read stage.
- rr_ptr  out  ISSUE_WIDTH*IQ_PTR_W  pointer of the presented op.
- rr_payload  out  ISSUE_WIDTH*PAYLOAD_W  payload of the presented op.
- release_valid  out  ISSUE_WIDTH  registered pulse: entry freed.
- release_ptr  out  ISSUE_WIDTH*IQ_PTR_W  freed entry.
- issued_cnt  out  CNT_W  saturating count of ops that left the stage.
- dup_err  out  1  sticky error: two valid lanes hold the same pointer.

Behaviour:
- Reset (async, rst=1):
  - All lane valid bits 0, pointers 0.
  - release_valid = 0, release_ptr = 0.
  - issued_cnt = 0, dup_err = 0.
  - Outputs reach these values immediately, without waiting for a clock edge.
- Per-lane latch state: lv[i], lp[i].
- flushed_held[i] = lv[i] && flush_iq_entry[lp[i]].
- flushed_in[i] = flush_iq_entry[sc_ptr[i]].
- Next-state priority, highest first:
  - clear: lv <= 0.
  - stall: lv[i] <= lv[i] && !flushed_held[i]; lp held. A flushed held op dies in place.
  - otherwise: lv[i] <= sc_valid[i] && !flushed_in[i]; lp[i] <= sc_ptr[i]. Pointer is loaded even when invalid.
- Outputs (combinational from the latch):
  - rr_valid[i] = lv[i] && !flushed_held[i] && !stall && !clear.
  - rr_ptr = lp.
  - rr_payload = iq_rd_payload.
  - iq_rd_ptr = lp.
- Latency: sc_valid at cycle N gives rr_valid at cycle N+1 if no stall, clear or flush.
- Release:
  - Registered one cycle after rr_valid: release_valid[i] <= rr_valid[i]; release_ptr[i] <= lp[i].
  - Flushed or cleared ops are not released here; recovery owns their deallocation.
- issued_cnt:
  - Adds popcount(rr_valid) each cycle.
  - Saturates at 2^CNT_W-1: never wraps; a sum exceeding the max clamps to the max.
- dup_err:
  - Set when any i≠j has lv[i] && lv[j] && lp[i]==lp[j].
  - Stays set until reset; clear does not reset it.
- Simultaneous events:
  - clear with stall: clear wins.
  - Flush of a held entry while stalled: the op is invalid on the next cycle and never released.
  - Same entry both flushed and newly selected: dropped.
- A stalled lane holding a valid op keeps rr_valid = 0 while stall = 1 and resumes presenting when stall falls, unless flushed meanwhile.

Test Plan:
- Basic issue: sc_valid=4'b0101, sc_ptr lanes 0/2 = 3/9, no stall → next cycle rr_valid=4'b0101, rr_ptr=3/9, payload from RAM; following cycle release_valid=4'b0101, ptr 3/9; issued_cnt=2.
- Stall hold: latch lane0 ptr 5, stall=1 for 3 cycles → rr_valid=0, release_valid=0, iq_rd_ptr lane0=5 held; stall drops → rr_valid[0]=1 ptr 5, issued_cnt +1.
- Flush while held: lane1 ptr 7 latched, stall=1, flush_iq_entry=1<<7 one cycle → after stall drops, rr_valid[1]=0, no release of 7, issued_cnt unchanged.
- Incoming flush + clear: sc_valid lane0 ptr 2 with flush_iq_entry bit2 → lane0 not latched; separately clear with stall both 1 → all lv=0.
- Saturation/duplicate: CNT_W=4 build, preload issued_cnt to 14, issue 4 ops → 15 and held; lanes 0 and 3 both valid ptr 11 → dup_err=1, persists after clear, 0 only after rst.
- Async reset mid-operation: assert rst between edges with lanes valid → rr_valid, release_valid, issued_cnt go 0 before next clk edge.

Source files
------------

// File: rtl/issue_stage_latch_if.sv
// Schedule -> issue latch -> register-read bundle.
// slave is the latch view, master the surrounding pipeline.
interface issue_stage_latch_if #(
  parameter int ISSUE_WIDTH  = 4,
  parameter int IQ_ENTRY_NUM = 16,
  parameter int IQ_PTR_W     = $clog2(IQ_ENTRY_NUM),
  parameter int PAYLOAD_W    = 64
);
  logic [ISSUE_WIDTH-1:0]           sc_valid;
  logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  sc_ptr;
  logic [IQ_ENTRY_NUM-1:0]          flush_iq_entry;
  logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  iq_rd_ptr;
  logic [ISSUE_WIDTH*PAYLOAD_W-1:0] iq_rd_payload;
  logic [ISSUE_WIDTH-1:0]           rr_valid;
  logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  rr_ptr;
  logic [ISSUE_WIDTH*PAYLOAD_W-1:0] rr_payload;
  logic [ISSUE_WIDTH-1:0]           release_valid;
  logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  release_ptr;

  modport master (
    output sc_valid, sc_ptr, flush_iq_entry,
    output iq_rd_payload,
    input  iq_rd_ptr, rr_valid, rr_ptr,
    input  rr_payload, release_valid, release_ptr
  );

  modport slave (
    input  sc_valid, sc_ptr, flush_iq_entry,
    input  iq_rd_payload,
    output iq_rd_ptr, rr_valid, rr_ptr,
    output rr_payload, release_valid, release_ptr
  );
endinterface

// File: rtl/issue_stage_latch.sv
// Per-lane issue latch: holds scheduled IQ pointers,
// kills flushed ops, releases entries, counts issues.
module issue_stage_latch #(
  parameter int ISSUE_WIDTH  = 4,
  parameter int IQ_ENTRY_NUM = 16,
  parameter int IQ_PTR_W     = $clog2(IQ_ENTRY_NUM),
  parameter int PAYLOAD_W    = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             clear,
  issue_stage_latch_if.slave bus,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             dup_err
);

  typedef logic [ISSUE_WIDTH-1:0][IQ_PTR_W-1:0] ptr_vec_t;

  logic [ISSUE_WIDTH-1:0] lv, lv_nxt;
  ptr_vec_t               lp, lp_nxt;
  ptr_vec_t               sp;
  ptr_vec_t               rp;
  logic [ISSUE_WIDTH-1:0] rv;
  logic [ISSUE_WIDTH-1:0] fh, fi;
  logic [ISSUE_WIDTH-1:0] rr_v;
  logic [CNT_W:0]         pop;
  logic [CNT_W:0]         sum;
  logic                   dup_now;

  assign sp = bus.sc_ptr;

  always_comb begin
    fh = '0;
    fi = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      fh[i] = lv[i] && bus.flush_iq_entry[lp[i]];
      fi[i] = bus.flush_iq_entry[sp[i]];
    end
  end

  // clear beats stall, stall beats a fresh load
  always_comb begin
    lv_nxt = lv;
    lp_nxt = lp;
    if (clear) begin
      lv_nxt = '0;
    end else if (stall) begin
      lv_nxt = lv & ~fh;
    end else begin
      lv_nxt = bus.sc_valid & ~fi;
      lp_nxt = sp;
    end
  end

  assign rr_v = lv & ~fh & {ISSUE_WIDTH{~stall & ~clear}};

  assign bus.rr_valid      = rr_v;
  assign bus.rr_ptr        = lp;
  assign bus.iq_rd_ptr     = lp;
  assign bus.rr_payload    = bus.iq_rd_payload;
  assign bus.release_valid = rv;
  assign bus.release_ptr   = rp;

  always_comb begin
    pop = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++)
      pop = pop + {{CNT_W{1'b0}}, rr_v[i]};
    sum = {1'b0, issued_cnt} + pop;
  end

  always_comb begin
    dup_now = 1'b0;
    for (int i = 0; i < ISSUE_WIDTH; i++)
      for (int j = i + 1; j < ISSUE_WIDTH; j++)
        if (lv[i] && lv[j] && lp[i] == lp[j])
          dup_now = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lv         <= '0;
      lp         <= '0;
      rv         <= '0;
      rp         <= '0;
      issued_cnt <= '0;
      dup_err    <= 1'b0;
    end else begin
      lv      <= lv_nxt;
      lp      <= lp_nxt;
      rv      <= rr_v;
      rp      <= lp;
      dup_err <= dup_err | dup_now;
      if (sum[CNT_W])
        issued_cnt <= '1;
      else
        issued_cnt <= sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_issue_stage_latch.sv
// Directed bench for issue_stage_latch.
// Main build CNT_W=32, second build CNT_W=4 for saturation.
module tb_issue_stage_latch;
  logic clk = 1'b0;
  logic rst;
  logic stall, clear;
  logic stall4, clear4;
  logic [31:0] cnt;
  logic [3:0]  cnt4;
  logic dup, dup4;
  int total = 0;
  int bad = 0;

  issue_stage_latch_if bus();
  issue_stage_latch_if bus4();

  issue_stage_latch dut (
    .clk(clk), .rst(rst),
    .stall(stall), .clear(clear),
    .bus(bus),
    .issued_cnt(cnt), .dup_err(dup)
  );

  issue_stage_latch #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .stall(stall4), .clear(clear4),
    .bus(bus4),
    .issued_cnt(cnt4), .dup_err(dup4)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++)
      bus.iq_rd_payload[i*64 +: 64] =
        {56'hC0FFEE00000000, 4'(i),
         bus.iq_rd_ptr[i*4 +: 4]};
  end
  assign bus4.iq_rd_payload = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 0; clear = 0;
    stall4 = 0; clear4 = 0;
    bus.sc_valid = '0; bus.sc_ptr = '0;
    bus.flush_iq_entry = '0;
    bus4.sc_valid = '0; bus4.sc_ptr = '0;
    bus4.flush_iq_entry = '0;
    #2;
    total++;
    if (bus.rr_valid !== 4'b0000) begin
      bad++;
      $display("FAIL reset_rr_valid got=%b exp=0000",
               bus.rr_valid);
    end
    total++;
    if (bus.release_valid !== 4'b0000 ||
        bus.release_ptr !== 16'h0) begin
      bad++;
      $display("FAIL reset_release got=%b/%h exp=0/0",
               bus.release_valid, bus.release_ptr);
    end
    total++;
    if (cnt !== 32'd0 || dup !== 1'b0 ||
        bus.rr_ptr !== 16'h0) begin
      bad++;
      $display("FAIL reset_cnt_dup got=%0d/%b/%h exp=0/0/0",
               cnt, dup, bus.rr_ptr);
    end
    #10;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bus.sc_valid = 4'b0101;
    bus.sc_ptr = {4'd0, 4'd9, 4'd0, 4'd3};
    step();
    total++;
    if (bus.rr_valid !== 4'b0101) begin
      bad++;
      $display("FAIL basic_rr_valid got=%b exp=0101",
               bus.rr_valid);
    end
    total++;
    if (bus.rr_ptr[3:0] !== 4'd3 ||
        bus.rr_ptr[11:8] !== 4'd9) begin
      bad++;
      $display("FAIL basic_rr_ptr got=%h exp=lane0 3 lane2 9",
               bus.rr_ptr);
    end
    total++;
    if (bus.rr_payload[63:0] !== 64'hC0FFEE00000000_03 ||
        bus.rr_payload[191:128] !== 64'hC0FFEE00000000_29)
    begin
      bad++;
      $display("FAIL basic_payload got=%h/%h",
               bus.rr_payload[63:0],
               bus.rr_payload[191:128]);
    end
    bus.sc_valid = 4'b0000;
    step();
    total++;
    if (bus.release_valid !== 4'b0101 ||
        bus.release_ptr[3:0] !== 4'd3 ||
        bus.release_ptr[11:8] !== 4'd9) begin
      bad++;
      $display("FAIL basic_release got=%b/%h exp=0101 3/9",
               bus.release_valid, bus.release_ptr);
    end
    total++;
    if (cnt !== 32'd2) begin
      bad++;
      $display("FAIL basic_cnt got=%0d exp=2", cnt);
    end
  endtask

  task automatic test_stall();
    bus.sc_valid = 4'b0001;
    bus.sc_ptr = {4'd0, 4'd0, 4'd0, 4'd5};
    step();
    stall = 1'b1;
    bus.sc_valid = '0;
    bus.sc_ptr = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (bus.rr_valid !== 4'b0 ||
          bus.release_valid !== 4'b0 ||
          bus.iq_rd_ptr[3:0] !== 4'd5) begin
        bad++;
        $display("FAIL stall_hold%0d got=%b/%b/%h exp=0/0/5",
                 k, bus.rr_valid, bus.release_valid,
                 bus.iq_rd_ptr[3:0]);
      end
    end
    stall = 1'b0;
    #1;
    total++;
    if (bus.rr_valid !== 4'b0001 ||
        bus.rr_ptr[3:0] !== 4'd5) begin
      bad++;
      $display("FAIL stall_resume got=%b/%h exp=0001/5",
               bus.rr_valid, bus.rr_ptr[3:0]);
    end
    step();
    total++;
    if (cnt !== 32'd3 || bus.release_valid !== 4'b0001 ||
        bus.release_ptr[3:0] !== 4'd5) begin
      bad++;
      $display("FAIL stall_release got=%0d/%b/%h exp=3/0001/5",
               cnt, bus.release_valid, bus.release_ptr[3:0]);
    end
  endtask

  task automatic test_flush_held();
    bus.sc_valid = 4'b0010;
    bus.sc_ptr = {4'd0, 4'd0, 4'd7, 4'd0};
    step();
    stall = 1'b1;
    bus.sc_valid = '0;
    bus.sc_ptr = '0;
    step();
    bus.flush_iq_entry = 16'h0080;
    #1;
    total++;
    if (bus.rr_valid !== 4'b0) begin
      bad++;
      $display("FAIL flush_during got=%b exp=0000",
               bus.rr_valid);
    end
    step();
    bus.flush_iq_entry = '0;
    step();
    stall = 1'b0;
    #1;
    total++;
    if (bus.rr_valid !== 4'b0) begin
      bad++;
      $display("FAIL flush_after got=%b exp=0000",
               bus.rr_valid);
    end
    step();
    total++;
    if (bus.release_valid !== 4'b0 || cnt !== 32'd3) begin
      bad++;
      $display("FAIL flush_norel got=%b/%0d exp=0000/3",
               bus.release_valid, cnt);
    end
  endtask

  task automatic test_in_flush_clear();
    bus.sc_valid = 4'b0001;
    bus.sc_ptr = {4'd0, 4'd0, 4'd0, 4'd2};
    bus.flush_iq_entry = 16'h0004;
    step();
    bus.flush_iq_entry = '0;
    bus.sc_valid = '0;
    #1;
    total++;
    if (bus.rr_valid !== 4'b0) begin
      bad++;
      $display("FAIL inflush got=%b exp=0000", bus.rr_valid);
    end
    bus.sc_valid = 4'b1111;
    bus.sc_ptr = {4'd4, 4'd3, 4'd2, 4'd1};
    step();
    total++;
    if (bus.rr_valid !== 4'b1111) begin
      bad++;
      $display("FAIL clr_load got=%b exp=1111", bus.rr_valid);
    end
    clear = 1'b1;
    stall = 1'b1;
    bus.sc_valid = '0;
    #1;
    total++;
    if (bus.rr_valid !== 4'b0) begin
      bad++;
      $display("FAIL clr_comb got=%b exp=0000", bus.rr_valid);
    end
    step();
    clear = 1'b0;
    stall = 1'b0;
    #1;
    total++;
    if (bus.rr_valid !== 4'b0 || cnt !== 32'd3 ||
        dup !== 1'b0) begin
      bad++;
      $display("FAIL clr_after got=%b/%0d/%b exp=0000/3/0",
               bus.rr_valid, cnt, dup);
    end
  endtask

  task automatic test_dup();
    bus.sc_valid = 4'b1001;
    bus.sc_ptr = {4'd11, 4'd0, 4'd0, 4'd11};
    step();
    bus.sc_valid = '0;
    bus.sc_ptr = '0;
    step();
    total++;
    if (dup !== 1'b1 || cnt !== 32'd5) begin
      bad++;
      $display("FAIL dup_set got=%b/%0d exp=1/5", dup, cnt);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    total++;
    if (dup !== 1'b1) begin
      bad++;
      $display("FAIL dup_sticky got=%b exp=1", dup);
    end
  endtask

  task automatic test_saturate();
    bus4.sc_valid = 4'b1111;
    bus4.sc_ptr = {4'd3, 4'd2, 4'd1, 4'd0};
    step();
    step();
    step();
    bus4.sc_valid = 4'b0011;
    step();
    total++;
    if (cnt4 !== 4'd12) begin
      bad++;
      $display("FAIL sat_12 got=%0d exp=12", cnt4);
    end
    bus4.sc_valid = 4'b1111;
    step();
    total++;
    if (cnt4 !== 4'd14) begin
      bad++;
      $display("FAIL sat_14 got=%0d exp=14", cnt4);
    end
    step();
    total++;
    if (cnt4 !== 4'd15) begin
      bad++;
      $display("FAIL sat_clamp got=%0d exp=15", cnt4);
    end
    step();
    step();
    total++;
    if (cnt4 !== 4'd15 || dup4 !== 1'b0) begin
      bad++;
      $display("FAIL sat_hold got=%0d/%b exp=15/0",
               cnt4, dup4);
    end
    bus4.sc_valid = '0;
  endtask

  task automatic test_async_reset();
    bus.sc_valid = 4'b1111;
    bus.sc_ptr = {4'd7, 4'd6, 4'd5, 4'd4};
    step();
    step();
    total++;
    if (bus.release_valid !== 4'b1111 || cnt !== 32'd9) begin
      bad++;
      $display("FAIL arst_pre got=%b/%0d exp=1111/9",
               bus.release_valid, cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.rr_valid !== 4'b0 ||
        bus.release_valid !== 4'b0) begin
      bad++;
      $display("FAIL arst_valid got=%b/%b exp=0/0",
               bus.rr_valid, bus.release_valid);
    end
    total++;
    if (cnt !== 32'd0 || dup !== 1'b0 || cnt4 !== 4'd0 ||
        bus.rr_ptr !== 16'h0) begin
      bad++;
      $display("FAIL arst_state got=%0d/%b/%0d/%h exp=0/0/0/0",
               cnt, dup, cnt4, bus.rr_ptr);
    end
    bus.sc_valid = '0;
    bus.sc_ptr = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush_held();
    test_in_flush_clear();
    test_dup();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
